// File: rtl/rr_req_gnt_arb.sv
// Round-robin request/grant arbiter with programmable grant latency.
// Optional per-grant hold limit enabled by defining REQ_GNT_HOLD_LIMIT_EN.
module rr_req_gnt_arb #(
  parameter int NUM_CH   = 4,
  parameter int LATENCY  = 2,
  parameter int CNT_W    = 16,
  parameter int MAX_HOLD = 8,
  localparam int IDW     = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDW-1:0]    gnt_id,
  output logic              gnt_valid,
  output logic              busy,
  output logic              hold_expired,
  output logic [CNT_W-1:0]  grant_count,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int LW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     win_q, win_d;
  logic [LW-1:0]      dly_q, dly_d;
  logic [NUM_CH-1:0]  gnt_q, gnt_d;
  logic [CNT_W-1:0]   gcnt_q, gcnt_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;

  logic [IDW-1:0]     base;
  logic [IDW-1:0]     cand;
  logic [IDW-1:0]     pick_id;
  logic               pick_found;

`ifdef REQ_GNT_HOLD_LIMIT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0]      hold_q, hold_d;
  logic               hexp_q, hexp_d;
`endif

  // RELEASE arbitrates with the just-finished winner as the new pointer,
  // so the release cycle doubles as the next request sample.
  always_comb begin
    base       = (state_q == RELEASE) ? win_q : ptr_q;
    cand       = '0;
    pick_id    = '0;
    pick_found = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = IDW'((int'(base) + k) % NUM_CH);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    dly_d   = dly_q;
    gnt_d   = gnt_q;
    gcnt_d  = gcnt_q;
    cyc_d   = cyc_q + 1'b1;
`ifdef REQ_GNT_HOLD_LIMIT_EN
    hold_d  = hold_q;
    hexp_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE, RELEASE: begin
        if (state_q == RELEASE) begin
          ptr_d = win_q;
        end
        state_d = IDLE;
        if (pick_found) begin
          win_d   = pick_id;
          dly_d   = LW'(LATENCY - 1);
          state_d = PEND;
        end
      end
      PEND: begin
        if (!req[win_q]) begin
          state_d = IDLE;
        end else if (dly_q == '0) begin
          state_d = GRANT;
          gnt_d   = NUM_CH'(1) << win_q;
          gcnt_d  = gcnt_q + 1'b1;
`ifdef REQ_GNT_HOLD_LIMIT_EN
          hold_d  = HW'(1);
`endif
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end
      GRANT: begin
        if (!req[win_q]) begin
          state_d = RELEASE;
          gnt_d   = '0;
`ifdef REQ_GNT_HOLD_LIMIT_EN
        end else if (hold_q == HW'(MAX_HOLD)) begin
          state_d = RELEASE;
          gnt_d   = '0;
          hexp_d  = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= IDW'(NUM_CH - 1);
      win_q   <= '0;
      dly_q   <= '0;
      gnt_q   <= '0;
      gcnt_q  <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      dly_q   <= dly_d;
      gnt_q   <= gnt_d;
      gcnt_q  <= gcnt_d;
      cyc_q   <= cyc_d;
    end
  end

`ifdef REQ_GNT_HOLD_LIMIT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q <= '0;
      hexp_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      hexp_q <= hexp_d;
    end
  end

  assign hold_expired = hexp_q;
`else
  assign hold_expired = 1'b0;
`endif

  assign gnt         = gnt_q;
  assign gnt_id      = win_q;
  assign gnt_valid   = |gnt_q;
  assign busy        = (state_q != IDLE);
  assign grant_count = gcnt_q;
  assign cycle_count = cyc_q;

endmodule
